// File: rtl/fifo_pkg.sv
// Shared definitions for param_fifo: default geometry, status-bus bit
// positions and a constant-evaluable ceil(log2) helper.
package fifo_pkg;

    localparam int DEF_DATA_W = 32'd32;
    localparam int DEF_DEPTH  = 32'd8;

    // Bit positions of the packed status vector {almost_empty, almost_full, empty, full}
    localparam int ST_FULL   = 32'd0;
    localparam int ST_EMPTY  = 32'd1;
    localparam int ST_AFULL  = 32'd2;
    localparam int ST_AEMPTY = 32'd3;
    localparam int ST_W      = 32'd4;

    // Number of bits needed to address 'value' entries (value >= 2)
    function automatic int clog2(input int value);
        int res;
        int rem;
        res = 32'd0;
        rem = value - 32'd1;
        while (rem > 32'd0) begin
            res = res + 32'd1;
            rem = rem >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/param_fifo_if.sv
// Handshake/data bundle between a producer/consumer pair and param_fifo.
// master: the side that issues requests; slave: the FIFO itself.
interface param_fifo_if
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
);
    localparam int AW = clog2(DEPTH);

    logic              flush;
    logic              wr_en;
    logic [DATA_W-1:0] d_in;
    logic              rd_en;
    logic [DATA_W-1:0] d_out;
    logic [AW:0]       data_count;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic              wr_ack;
    logic              wr_err;
    logic              rd_ack;
    logic              rd_err;

    modport master (
        output flush, wr_en, d_in, rd_en,
        input  d_out, data_count, full, empty, almost_full, almost_empty,
               wr_ack, wr_err, rd_ack, rd_err
    );

    modport slave (
        input  flush, wr_en, d_in, rd_en,
        output d_out, data_count, full, empty, almost_full, almost_empty,
               wr_ack, wr_err, rd_ack, rd_err
    );

endinterface

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous
// read port. Contents are intentionally not reset.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]       wdata,
    input  logic [clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]       rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Store write data at the write address when a write is accepted
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/param_fifo.sv
// Parametrised synchronous FIFO with registered occupancy, almost-full /
// almost-empty flags, synchronous flush and ack/err handshake pulses.
// Optional macro FIFO_FWFT_EN selects first-word-fall-through output;
// without it d_out is a registered read, valid the cycle after rd_ack's edge.
module param_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 32'd2,
    parameter int AE_LEVEL = 32'd2
) (
    input  logic         clk,
    input  logic         reset_n,
    param_fifo_if.slave  bus
);

    localparam int AW = clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];
    localparam logic [AW:0] AF_C    = AF_LEVEL[AW:0];
    localparam logic [AW:0] AE_C    = AE_LEVEL[AW:0];
    localparam logic [AW:0] ZERO_C  = {(AW+1){1'b0}};

    // Flag vector for a given occupancy; used for next-state and reset values
    function automatic logic [ST_W-1:0] flags_of(input logic [AW:0] cnt);
        logic [ST_W-1:0] f;
        f            = {ST_W{1'b0}};
        f[ST_FULL]   = (cnt == DEPTH_C);
        f[ST_EMPTY]  = (cnt == ZERO_C);
        f[ST_AFULL]  = (cnt >= AF_C);
        f[ST_AEMPTY] = (cnt <= AE_C);
        return f;
    endfunction

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic [ST_W-1:0]   status_q, status_d;
    logic              wr_ack_q, wr_ack_d;
    logic              wr_err_q, wr_err_d;
    logic              rd_ack_q, rd_ack_d;
    logic              rd_err_q, rd_err_d;
    logic              wr_acc_s;
    logic              rd_acc_s;
    logic              mem_we_s;
    logic [DATA_W-1:0] rdata_s;

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we_s),
        .waddr (wr_ptr_q),
        .wdata (bus.d_in),
        .raddr (rd_ptr_q),
        .rdata (rdata_s)
    );

    // Acceptance: a read needs data; a write needs space, or a same-cycle
    // read that frees the slot (a full FIFO is never empty since DEPTH >= 2)
    always_comb begin
        rd_acc_s = bus.rd_en & ~status_q[ST_EMPTY];
        wr_acc_s = bus.wr_en & (~status_q[ST_FULL] | bus.rd_en);
        mem_we_s = wr_acc_s & ~bus.flush;
    end

    // Next-state for pointers, occupancy, flags and handshake pulses; flush wins
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        status_d = status_q;
        wr_ack_d = 1'b0;
        wr_err_d = 1'b0;
        rd_ack_d = 1'b0;
        rd_err_d = 1'b0;
        if (bus.flush) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = ZERO_C;
            status_d = flags_of(ZERO_C);
        end else begin
            if (wr_acc_s) begin
                wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (rd_acc_s) begin
                rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d  = count_q + {{AW{1'b0}}, wr_acc_s} - {{AW{1'b0}}, rd_acc_s};
            status_d = flags_of(count_d);
            wr_ack_d = wr_acc_s;
            wr_err_d = bus.wr_en & ~wr_acc_s;
            rd_ack_d = rd_acc_s;
            rd_err_d = bus.rd_en & ~rd_acc_s;
        end
    end

    // Control state registers with asynchronous reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= ZERO_C;
            status_q <= flags_of(ZERO_C);
            wr_ack_q <= 1'b0;
            wr_err_q <= 1'b0;
            rd_ack_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            status_q <= status_d;
            wr_ack_q <= wr_ack_d;
            wr_err_q <= wr_err_d;
            rd_ack_q <= rd_ack_d;
            rd_err_q <= rd_err_d;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head of queue is always presented; forced to zero while empty
    always_comb begin
        if (status_q[ST_EMPTY]) begin
            bus.d_out = {DATA_W{1'b0}};
        end else begin
            bus.d_out = rdata_s;
        end
    end
`else
    logic [DATA_W-1:0] dout_q, dout_d;

    // Capture the head word on an accepted read; hold otherwise (including flush)
    always_comb begin
        if (rd_acc_s && !bus.flush) begin
            dout_d = rdata_s;
        end else begin
            dout_d = dout_q;
        end
    end

    // Registered read data with asynchronous reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout_q <= {DATA_W{1'b0}};
        end else begin
            dout_q <= dout_d;
        end
    end

    assign bus.d_out = dout_q;
`endif

    assign bus.data_count   = count_q;
    assign bus.full         = status_q[ST_FULL];
    assign bus.empty        = status_q[ST_EMPTY];
    assign bus.almost_full  = status_q[ST_AFULL];
    assign bus.almost_empty = status_q[ST_AEMPTY];
    assign bus.wr_ack       = wr_ack_q;
    assign bus.wr_err       = wr_err_q;
    assign bus.rd_ack       = rd_ack_q;
    assign bus.rd_err       = rd_err_q;

endmodule
